// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin arbiter merging two register-file writeback
// requesters (A = ALU, B = load) into a single registered write stage.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   a_valid/a_reg/a_data  requester A write request (index, data)
//   a_ready               A handshake accepted this cycle (combinational)
//   b_valid/b_reg/b_data  requester B write request
//   b_ready               B handshake accepted this cycle (combinational)
//   wp_busy               register-file write port stalled, holds the stage
//   wr_en                 one-hot write enables, bit i writes Ri
//   wr_reg, wr_data       index and data of the write in the output stage
//   pending               bit i set while an accepted write to Ri is in flight
//   bad_reg               one-cycle pulse for a dropped write to a non-writable index
//   wr_count              number of retired writes (wraps)
module reg_wb_arbiter #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [3:0]      a_reg,
  input  logic [DW-1:0]   a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [3:0]      b_reg,
  input  logic [DW-1:0]   b_data,
  input  logic            wp_busy,
  output logic [NREG-1:0] wr_en,
  output logic [3:0]      wr_reg,
  output logic [DW-1:0]   wr_data,
  output logic [NREG-1:0] pending,
  output logic            bad_reg,
  output logic [15:0]     wr_count
);

  localparam int unsigned CNT_W  = 16;
  localparam logic [4:0]  NREG_L = 5'(NREG);
  localparam logic        GRANT_A = 1'b0;
  localparam logic        GRANT_B = 1'b1;

  // Decode a register index into a one-hot enable vector.
  function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      oh[i] = (idx == 4'(i));
    end
    return oh;
  endfunction

  // State
  logic             r_out_v;
  logic             r_last_grant;
  logic             r_bad_reg;
  logic [3:0]       r_wr_reg;
  logic [DW-1:0]    r_wr_data;
  logic [NREG-1:0]  r_wr_en;
  logic [NREG-1:0]  r_pending;
  logic [CNT_W-1:0] r_wr_count;

  // Next-state values
  logic             w_nxt_out_v;
  logic             w_nxt_last_grant;
  logic             w_nxt_bad_reg;
  logic [3:0]       w_nxt_wr_reg;
  logic [DW-1:0]    w_nxt_wr_data;
  logic [NREG-1:0]  w_nxt_wr_en;
  logic [NREG-1:0]  w_nxt_pending;
  logic [CNT_W-1:0] w_nxt_wr_count;

  // Handshake / arbitration
  logic             w_can_accept;
  logic             w_retire;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_hs;
  logic [3:0]       w_idx;
  logic [DW-1:0]    w_data;
  logic             w_drop;
  logic [NREG-1:0]  w_idx_oh;

  // Stage frees up either when empty or when its write retires this cycle.
  assign w_can_accept = !r_out_v || !wp_busy;
  assign w_retire     = r_out_v && !wp_busy;

  // Round-robin: on a conflict the requester not granted last wins.
  // Readies depend only on valids, last grant, stage state and stall.
  assign w_grant_a = !rst && w_can_accept && a_valid &&
                     (!b_valid || (r_last_grant == GRANT_B));
  assign w_grant_b = !rst && w_can_accept && b_valid &&
                     (!a_valid || (r_last_grant == GRANT_A));
  assign w_hs      = w_grant_a || w_grant_b;

  assign w_idx    = w_grant_b ? b_reg  : a_reg;
  assign w_data   = w_grant_b ? b_data : a_data;
  // Any index past the last writable register (4'hF at the default size) is dropped.
  assign w_drop   = ({1'b0, w_idx} >= NREG_L);
  assign w_idx_oh = onehot(w_idx);

  // Next-state computation for the output stage and bookkeeping.
  always_comb begin
    w_nxt_out_v      = r_out_v;
    w_nxt_last_grant = r_last_grant;
    w_nxt_wr_reg     = r_wr_reg;
    w_nxt_wr_data    = r_wr_data;
    w_nxt_wr_en      = r_wr_en;
    w_nxt_bad_reg    = 1'b0;

    if (w_retire) begin
      w_nxt_out_v = 1'b0;
      w_nxt_wr_en = '0;
    end

    if (w_hs) begin
      w_nxt_out_v      = !w_drop;
      w_nxt_wr_reg     = w_idx;
      w_nxt_wr_data    = w_data;
      w_nxt_wr_en      = w_drop ? '0 : w_idx_oh;
      w_nxt_last_grant = w_grant_b ? GRANT_B : GRANT_A;
      w_nxt_bad_reg    = w_drop;
    end

    // Set wins over clear so a same-register retire+accept keeps the bit.
    w_nxt_pending  = (r_pending & ~({NREG{w_retire}} & r_wr_en)) |
                     ({NREG{w_hs && !w_drop}} & w_idx_oh);
    w_nxt_wr_count = r_wr_count + CNT_W'(w_retire);
  end

  // State register; reset discards any write sitting in the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_v      <= 1'b0;
      r_last_grant <= GRANT_B;
      r_bad_reg    <= 1'b0;
      r_wr_reg     <= '0;
      r_wr_data    <= '0;
      r_wr_en      <= '0;
      r_pending    <= '0;
      r_wr_count   <= '0;
    end else begin
      r_out_v      <= w_nxt_out_v;
      r_last_grant <= w_nxt_last_grant;
      r_bad_reg    <= w_nxt_bad_reg;
      r_wr_reg     <= w_nxt_wr_reg;
      r_wr_data    <= w_nxt_wr_data;
      r_wr_en      <= w_nxt_wr_en;
      r_pending    <= w_nxt_pending;
      r_wr_count   <= w_nxt_wr_count;
    end
  end

  assign a_ready  = w_grant_a;
  assign b_ready  = w_grant_b;
  assign wr_en    = r_wr_en;
  assign wr_reg   = r_wr_reg;
  assign wr_data  = r_wr_data;
  assign pending  = r_pending;
  assign bad_reg  = r_bad_reg;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the writeback arbiter.
module tb_reg_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [3:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        wp_busy;
  logic [14:0] wr_en;
  logic [3:0]  wr_reg;
  logic [31:0] wr_data;
  logic [14:0] pending;
  logic        bad_reg;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  // Reference model: the single write in flight, outstanding writes per
  // register, retired count and who won the last handshake.
  bit          m_out_v;
  logic [3:0]  m_reg;
  logic [31:0] m_data;
  bit          m_last_b;
  int          m_pend [16];
  logic [15:0] m_count;
  bit          m_bad;
  bit          m_rst_last;

  reg_wb_arbiter #(.DW(32), .NREG(15)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .wp_busy(wp_busy),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .pending(pending), .bad_reg(bad_reg), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check readies, advance model, check outputs.
  task automatic cycle(input bit av, input logic [3:0] ar, input logic [31:0] ad,
                       input bit bv, input logic [3:0] br, input logic [31:0] bd,
                       input bit busy, input bit r);
    bit ea, eb;
    logic [3:0]  idx;
    logic [31:0] dat;
    logic [14:0] e_en, e_pend;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    wp_busy = busy; rst = r;
    #1;
    ea = 0; eb = 0;
    if (!r && (!m_out_v || !busy)) begin
      if (av && bv) begin
        if (m_last_b) ea = 1; else eb = 1;
      end else if (av) ea = 1;
      else if (bv) eb = 1;
    end
    check("a_ready", 32'(a_ready), 32'(ea));
    check("b_ready", 32'(b_ready), 32'(eb));

    if (r) begin
      m_out_v = 0; m_reg = '0; m_data = '0; m_last_b = 1; m_count = '0; m_bad = 0;
      for (int i = 0; i < 16; i++) m_pend[i] = 0;
    end else begin
      if (m_out_v && !busy) begin
        m_count = m_count + 16'd1;
        m_pend[m_reg] = m_pend[m_reg] - 1;
        m_out_v = 0;
      end
      m_bad = 0;
      if (ea || eb) begin
        idx = ea ? ar : br;
        dat = ea ? ad : bd;
        m_last_b = eb;
        if (idx == 4'hF) m_bad = 1;
        else begin
          m_out_v = 1; m_reg = idx; m_data = dat;
          m_pend[idx] = m_pend[idx] + 1;
        end
      end
    end
    m_rst_last = r;

    @(posedge clk); #1;
    e_en = '0;
    if (m_out_v) e_en[m_reg] = 1'b1;
    e_pend = '0;
    for (int i = 0; i < 15; i++) e_pend[i] = (m_pend[i] > 0);
    check("wr_en", 32'(wr_en), 32'(e_en));
    check("pending", 32'(pending), 32'(e_pend));
    check("bad_reg", 32'(bad_reg), 32'(m_bad));
    check("wr_count", 32'(wr_count), 32'(m_count));
    if (m_out_v || m_rst_last) begin
      check("wr_reg", 32'(wr_reg), 32'(m_reg));
      check("wr_data", wr_data, m_data);
    end
  endtask

  task automatic idle();
    cycle(0, 4'h0, 32'h0, 0, 4'h0, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(0, 4'h0, 32'h0, 0, 4'h0, 32'h0, 0, 1);
    cycle(0, 4'h0, 32'h0, 0, 4'h0, 32'h0, 0, 1);
  endtask

  initial begin
    bit av, bv, busy, r;
    logic [3:0] ar, br;
    m_out_v = 0; m_reg = '0; m_data = '0; m_last_b = 1; m_count = '0;
    m_bad = 0; m_rst_last = 0;
    for (int i = 0; i < 16; i++) m_pend[i] = 0;

    // Reset state
    do_reset();
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_count", 32'(wr_count), 32'h0);

    // Single A write to R3
    cycle(1, 4'd3, 32'h1234, 0, 4'd0, 32'h0, 0, 0);
    check("s1_wr_en", 32'(wr_en), 32'h0008);
    check("s1_wr_data", wr_data, 32'h1234);
    check("s1_pend3", 32'(pending[3]), 32'h1);
    idle();
    check("s1_pend_clr", 32'(pending), 32'h0);
    check("s1_count", 32'(wr_count), 32'd1);

    // Alternating grants under continuous conflict
    do_reset();
    cycle(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB1, 0, 0);
    check("rr_en0", 32'(wr_en), 32'h0002);
    cycle(1, 4'd1, 32'hA2, 1, 4'd2, 32'hB1, 0, 0);
    check("rr_en1", 32'(wr_en), 32'h0004);
    cycle(1, 4'd1, 32'hA2, 1, 4'd2, 32'hB2, 0, 0);
    check("rr_en2", 32'(wr_en), 32'h0002);
    cycle(1, 4'd1, 32'hA3, 1, 4'd2, 32'hB2, 0, 0);
    check("rr_en3", 32'(wr_en), 32'h0004);
    idle();
    check("rr_count", 32'(wr_count), 32'd4);

    // Stall holds the stage and blocks both requesters
    cycle(0, 4'd0, 32'h0, 1, 4'd5, 32'h55, 0, 0);
    check("st_en0", 32'(wr_en), 32'h0020);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 4'd6, 32'h66, 1, 4'd8, 32'h88, 1, 0);
      check("st_hold", 32'(wr_en), 32'h0020);
      check("st_cnt_hold", 32'(wr_count), 32'd4);
    end
    idle();
    check("st_en_clr", 32'(wr_en), 32'h0);
    check("st_count", 32'(wr_count), 32'd5);

    // Write to index 4'hF is dropped
    cycle(1, 4'hF, 32'hDEAD, 0, 4'd0, 32'h0, 0, 0);
    check("bad_pulse", 32'(bad_reg), 32'h1);
    check("bad_wr_en", 32'(wr_en), 32'h0);
    check("bad_pend", 32'(pending), 32'h0);
    check("bad_count", 32'(wr_count), 32'd5);
    idle();
    check("bad_clr", 32'(bad_reg), 32'h0);

    // Same-register conflict: A then B
    do_reset();
    cycle(1, 4'd7, 32'hAAAA, 1, 4'd7, 32'hBBBB, 0, 0);
    check("cf_en0", 32'(wr_en), 32'h0080);
    check("cf_data0", wr_data, 32'hAAAA);
    cycle(0, 4'd0, 32'h0, 1, 4'd7, 32'hBBBB, 0, 0);
    check("cf_en1", 32'(wr_en), 32'h0080);
    check("cf_data1", wr_data, 32'hBBBB);
    check("cf_pend1", 32'(pending), 32'h0080);
    idle();
    check("cf_pend_clr", 32'(pending), 32'h0);
    check("cf_count", 32'(wr_count), 32'd2);

    // Reset discards an in-flight write
    do_reset();
    cycle(1, 4'd0, 32'h0F0F, 0, 4'd0, 32'h0, 1, 0);
    check("rd_en", 32'(wr_en), 32'h0001);
    cycle(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 1, 1);
    check("rd_en_clr", 32'(wr_en), 32'h0);
    check("rd_pend", 32'(pending), 32'h0);
    idle();
    check("rd_count", 32'(wr_count), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      av   = ($urandom_range(0, 2) != 0);
      bv   = ($urandom_range(0, 2) != 0);
      ar   = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      br   = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      busy = ($urandom_range(0, 3) == 0);
      r    = ($urandom_range(0, 59) == 0);
      cycle(av, ar, $urandom, bv, br, $urandom, busy, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, meaning register data width.
REQ-002 SHALL have parameter NREG, default 15, meaning number of writable registers (R0-R14); index 4'hF is never writable.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port a_valid  input  1  requester A (ALU writeback) has a write.
REQ-006 SHALL have port a_ready  output  1  requester A handshake accepted this cycle.
REQ-007 SHALL have port a_reg  input  4  requester A destination index.
REQ-008 SHALL have port a_data  input  DW  requester A write data.
REQ-009 SHALL have ports b_valid, b_ready, b_reg, b_data with the same directions, widths and meanings as the A ports, for requester B (load writeback).
REQ-010 SHALL have port wp_busy  input  1  register-file write port stalled; holds the output stage.
REQ-011 SHALL have port wr_en  output  NREG  one-hot register write enables, bit i enables Ri.
REQ-012 SHALL have port wr_reg  output  4  index of the current write.
REQ-013 SHALL have port wr_data  output  DW  data of the current write.
REQ-014 SHALL have port pending  output  NREG  bit i set while an accepted write to Ri has not retired.
REQ-015 SHALL have port bad_reg  output  1  one-cycle pulse for a dropped write to index 4'hF.
REQ-016 SHALL have port wr_count  output  16  count of retired writes, wraps at 16'hFFFF -> 0.

Function
REQ-017 SHALL implement a single output stage (out_v, wr_reg, wr_data); wr_en = out_v ? onehot(wr_reg) : 0, all registered.
REQ-018 SHALL retire a write in any cycle with out_v=1 and wp_busy=0; out_v, wr_reg and wr_data are held unchanged while wp_busy=1.
REQ-019 SHALL define can_accept = !out_v || !wp_busy; no a_ready/b_ready when can_accept=0.
REQ-020 SHALL assert at most one of a_ready/b_ready per cycle, and only to a requester with valid=1.
REQ-021 SHALL arbitrate round-robin on 1-bit last_grant: only A valid -> A; only B valid -> B; both valid -> the requester not granted last; last_grant updates on every handshake.
REQ-022 SHALL give a handshake in cycle N wr_en (one-hot) visible in cycle N+1; latency 1 cycle; throughput 1 write/cycle with wp_busy=0.
REQ-023 SHALL, for a handshake with index 4'hF, complete the handshake, load out_v=0 (no wr_en), pulse bad_reg in cycle N+1, and update last_grant.
REQ-024 SHALL set pending[i] on a handshake to Ri (i<15) and clear it on retirement; when retirement and a new handshake hit the same register in one cycle, pending stays set.
REQ-025 SHALL treat a same-register request from both A and B as an ordinary conflict: the loser waits and writes in a later cycle (last write wins in the register file).
REQ-026 SHALL increment wr_count by 1 per retired write; dropped 4'hF writes do not count.
REQ-027 SHALL make a_ready/b_ready combinational from valids, last_grant, out_v and wp_busy only (no path from data or index inputs).

Reset
REQ-028 SHALL, while rst=1, drive out_v=0, wr_en=0, wr_reg=0, wr_data=0, pending=0, bad_reg=0, wr_count=0, last_grant=B (so A wins the first conflict), a_ready=b_ready=0.
REQ-029 SHALL discard a write in the output stage when rst asserts mid-operation (it does not retire, count or leave pending set); operation resumes the cycle after rst deasserts.

Verification
REQ-030 SHALL pass: after reset, A valid, a_reg=3, a_data=32'h1234 -> a_ready=1 same cycle; next cycle wr_en=15'h0008, wr_data=32'h1234, pending[3]=1; following cycle pending=0, wr_count=1.
REQ-031 SHALL pass: A and B valid for 4 cycles, a_reg=1, b_reg=2, wp_busy=0 -> grants A,B,A,B; wr_en sequence 0x0002,0x0004,0x0002,0x0004; wr_count=4.
REQ-032 SHALL pass: B handshakes to R5, then wp_busy=1 for 3 cycles -> wr_en=0x0020 held 4 cycles, a_ready=b_ready=0 while held, wr_count increments once after wp_busy falls.
REQ-033 SHALL pass: A valid with a_reg=4'hF -> a_ready=1, next cycle bad_reg=1, wr_en=0, pending unchanged, wr_count unchanged.
REQ-034 SHALL pass: A and B both target R7 same cycle -> A written first then B (two consecutive wr_en=0x0080 cycles), pending[7] stays 1 across both, clears after second.
REQ-035 SHALL pass: rst asserted with a write in the output stage (wr_en=0x0001) -> next cycle wr_en=0, pending=0, wr_count unchanged from 0.
